// File: rtl/stack_push_pop_8x16.sv
// rtl/stack_push_pop_8x16.sv - DEPTH-entry operand stack with TOS/NOS taps and sticky error flags
// The stack pointer equals the entry count; reads below count are forced to zero.
module stack_push_pop_8x16 #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   input  logic             clear_err,
   output logic [WIDTH-1:0] tos,
   output logic [WIDTH-1:0] nos,
   output logic [AW:0]      count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [AW:0] SP_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] slot [DEPTH];
   logic [AW:0]      sp;
   logic [AW:0]      sp_m1;
   logic [AW:0]      sp_m2;

   assign sp_m1 = sp - SP_ONE;
   assign sp_m2 = sp_m1 - SP_ONE;

   assign count = sp;
   assign empty = (sp == '0);
   assign full  = (sp == SP_FULL);

   // Zero-gating keeps stale popped words from ever appearing on the taps.
   assign tos = empty              ? '0 : slot[sp_m1[AW-1:0]];
   assign nos = (sp[AW:1] == '0)   ? '0 : slot[sp_m2[AW-1:0]];

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         sp        <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            slot[i] <= '0;
         end
      end else begin
         if (clear_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end
         // Error sets come after the clear so a same-edge error wins.
         case ({push, pop})
            2'b10: begin
               if (full) begin
                  overflow <= 1'b1;
               end else begin
                  slot[sp[AW-1:0]] <= din;
                  sp               <= sp + SP_ONE;
               end
            end
            2'b01: begin
               if (empty) begin
                  underflow <= 1'b1;
               end else begin
                  sp <= sp_m1;
               end
            end
            2'b11: begin
               if (empty) begin
                  slot[0] <= din;
                  sp      <= SP_ONE;
               end else begin
                  slot[sp_m1[AW-1:0]] <= din;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_push_pop_8x16.sv
// tb/tb_stack_push_pop_8x16.sv - vector table, corner sequences and random run against a queue model
// Expected values come from constant tables or a queue-based stack model.
module tb_stack_push_pop_8x16;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        push = 1'b0;
   logic        pop = 1'b0;
   logic [15:0] din = '0;
   logic        clear_err = 1'b0;
   logic [15:0] tos, nos;
   logic [3:0]  count;
   logic        empty, full, overflow, underflow;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] mq[$];
   logic        m_ovf = 1'b0;
   logic        m_unf = 1'b0;

   typedef struct {
      logic        push, pop, clr;
      logic [15:0] din;
      logic [15:0] tos, nos;
      logic [3:0]  cnt;
      logic        ovf, unf;
   } vec_t;
   vec_t tbl[$];

   stack_push_pop_8x16 dut (
      .CLK(CLK), .Reset(Reset), .push(push), .pop(pop), .din(din),
      .clear_err(clear_err), .tos(tos), .nos(nos), .count(count),
      .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
   );

   always #5 CLK = ~CLK;

   function automatic void add(logic p, logic q, logic c, logic [15:0] d,
                               logic [15:0] et, logic [15:0] en, logic [3:0] ec,
                               logic eo, logic eu);
      vec_t v;
      v.push = p; v.pop = q; v.clr = c; v.din = d;
      v.tos = et; v.nos = en; v.cnt = ec; v.ovf = eo; v.unf = eu;
      tbl.push_back(v);
   endfunction

   task automatic check(string nm, logic [15:0] et, logic [15:0] en, logic [3:0] ec,
                        logic eo, logic eu);
      logic ee, ef;
      ee = (ec == 4'd0);
      ef = (ec == 4'd8);
      n_vec++;
      if ({tos, nos, count, empty, full, overflow, underflow} !== {et, en, ec, ee, ef, eo, eu}) begin
         n_err++;
         $display("FAIL %s: got tos=%h nos=%h cnt=%0d empty=%b full=%b ovf=%b unf=%b, expected tos=%h nos=%h cnt=%0d empty=%b full=%b ovf=%b unf=%b",
                  nm, tos, nos, count, empty, full, overflow, underflow, et, en, ec, ee, ef, eo, eu);
      end
   endtask

   task automatic model_check(string nm);
      int n;
      n = mq.size();
      check(nm, (n > 0) ? mq[n-1] : 16'h0, (n > 1) ? mq[n-2] : 16'h0, 4'(n), m_ovf, m_unf);
   endtask

   // Drive one request between edges, update the model, sample just after the edge.
   task automatic apply(logic p, logic q, logic c, logic [15:0] d);
      int n;
      @(negedge CLK);
      push = p; pop = q; clear_err = c; din = d;
      n = mq.size();
      if (c) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (p && !q) begin
         if (n < 8) mq.push_back(d);
         else m_ovf = 1'b1;
      end else if (q && !p) begin
         if (n > 0) void'(mq.pop_back());
         else m_unf = 1'b1;
      end else if (p && q) begin
         if (n > 0) mq[n-1] = d;
         else mq.push_back(d);
      end
      @(posedge CLK);
      #1;
      push = 1'b0; pop = 1'b0; clear_err = 1'b0;
   endtask

   task automatic async_reset(string nm);
      @(negedge CLK);
      #2;
      Reset = 1'b1;
      #1;
      check(nm, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      @(negedge CLK);
      Reset = 1'b0;
   endtask

   initial begin
      // Directed table: fill, overflow, drain, underflow, replace, set-wins.
      for (int k = 1; k <= 8; k++)
         add(1, 0, 0, 16'(k), 16'(k), 16'(k - 1), 4'(k), 0, 0);
      add(1, 0, 0, 16'hBEEF, 16'h0008, 16'h0007, 4'd8, 1, 0);
      add(0, 0, 1, 16'h0000, 16'h0008, 16'h0007, 4'd8, 0, 0);
      for (int j = 1; j <= 8; j++)
         add(0, 1, 0, 16'h0, 16'(8 - j), (j <= 6) ? 16'(7 - j) : 16'h0, 4'(8 - j), 0, 0);
      add(0, 1, 0, 16'h0, 16'h0, 16'h0, 4'd0, 0, 1);
      add(0, 0, 1, 16'h0, 16'h0, 16'h0, 4'd0, 0, 0);
      add(1, 0, 0, 16'h0011, 16'h0011, 16'h0000, 4'd1, 0, 0);
      add(1, 0, 0, 16'h0022, 16'h0022, 16'h0011, 4'd2, 0, 0);
      add(1, 1, 0, 16'h0033, 16'h0033, 16'h0011, 4'd2, 0, 0);
      add(0, 1, 0, 16'h0, 16'h0011, 16'h0000, 4'd1, 0, 0);
      add(0, 1, 0, 16'h0, 16'h0000, 16'h0000, 4'd0, 0, 0);
      add(1, 1, 0, 16'h0044, 16'h0044, 16'h0000, 4'd1, 0, 0);
      add(0, 1, 0, 16'h0, 16'h0000, 16'h0000, 4'd0, 0, 0);
      add(0, 1, 0, 16'h0, 16'h0000, 16'h0000, 4'd0, 0, 1);
      add(0, 1, 1, 16'h0, 16'h0000, 16'h0000, 4'd0, 0, 1);
      add(0, 0, 1, 16'h0, 16'h0000, 16'h0000, 4'd0, 0, 0);

      repeat (2) @(posedge CLK);
      #1;
      check("reset_held", 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
      @(negedge CLK);
      Reset = 1'b0;
      @(posedge CLK);
      #1;
      check("reset_released", 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].push, tbl[i].pop, tbl[i].clr, tbl[i].din);
         check($sformatf("tbl%0d", i), tbl[i].tos, tbl[i].nos, tbl[i].cnt, tbl[i].ovf, tbl[i].unf);
      end

      // Replace while full must not flag overflow; overflow set beats clear.
      async_reset("areset_pre_full");
      for (int k = 0; k < 8; k++) apply(1, 0, 0, 16'hA000 + 16'(k));
      check("full_fill", 16'hA007, 16'hA006, 4'd8, 1'b0, 1'b0);
      apply(1, 1, 0, 16'h5555);
      check("full_replace", 16'h5555, 16'hA006, 4'd8, 1'b0, 1'b0);
      apply(1, 0, 0, 16'h7777);
      check("full_overflow", 16'h5555, 16'hA006, 4'd8, 1'b1, 1'b0);
      apply(1, 0, 1, 16'h7777);
      check("ovf_set_wins", 16'h5555, 16'hA006, 4'd8, 1'b1, 1'b0);
      apply(0, 0, 1, 16'h0);
      check("ovf_cleared", 16'h5555, 16'hA006, 4'd8, 1'b0, 1'b0);

      // Asynchronous reset between edges with live contents.
      async_reset("areset_flush");
      apply(1, 0, 0, 16'h0101);
      apply(1, 0, 0, 16'h0202);
      apply(1, 0, 0, 16'h0303);
      check("three_pushed", 16'h0303, 16'h0202, 4'd3, 1'b0, 1'b0);
      async_reset("areset_mid_op");
      @(posedge CLK);
      #1;
      check("after_areset", 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);

      for (int i = 0; i < 800; i++) begin
         int pw, pp;
         pw = (i % 200 < 100) ? 70 : 30;
         pp = (i % 200 < 100) ? 35 : 70;
         apply($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pp,
               $urandom_range(0, 15) == 0, 16'($urandom));
         model_check($sformatf("rand%0d", i));
         if ($urandom_range(0, 299) == 0) async_reset($sformatf("rand_areset%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
